// File: rtl/cc_encoder.sv
// cc_encoder: MIDI Control Change transmitter. Sends one 3-byte CC message
// (status, controller, value) whenever a tracked synth parameter changes.
`default_nettype none

module cc_encoder #(
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] wtb_num,
    input  logic [6:0] wfm_num,
    input  logic       wtb_load_req,
    input  logic [6:0] adsr_a,
    input  logic [6:0] adsr_d,
    input  logic [6:0] adsr_s,
    input  logic [6:0] adsr_r,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy
);

    typedef enum logic [1:0] {S_IDLE, S_STATUS, S_NUM, S_VAL} state_t;

    localparam logic [7:0] STATUS_BYTE = {4'hB, CHANNEL};

    state_t     state_q, state_d;
    logic [2:0] rr_q, rr_d;
    logic       load_pend_q, load_pend_d;
    logic [6:0] msg_num_q, msg_num_d;
    logic [6:0] msg_val_q, msg_val_d;
    logic [6:0] shadow_q [1:6];
    logic [6:0] shadow_d [1:6];
    logic       tx_valid_q, tx_valid_d;
    logic [7:0] tx_data_q, tx_data_d;

    logic [6:0] src_val [7];
    logic [6:0] cc_num  [7];
    logic [6:0] pending;
    logic       found;
    logic [2:0] sel;
    logic [3:0] idx;

    // Index 0 is the wavetable-load request; its value byte is always zero.
    always_comb begin
        src_val[0] = 7'd0;     cc_num[0] = 7'd112;
        src_val[1] = wtb_num;  cc_num[1] = 7'd110;
        src_val[2] = wfm_num;  cc_num[2] = 7'd111;
        src_val[3] = adsr_a;   cc_num[3] = 7'd73;
        src_val[4] = adsr_d;   cc_num[4] = 7'd75;
        src_val[5] = adsr_s;   cc_num[5] = 7'd64;
        src_val[6] = adsr_r;   cc_num[6] = 7'd72;
        pending[0] = load_pend_q;
        for (int i = 1; i < 7; i++) begin
            pending[i] = (src_val[i] != shadow_q[i]);
        end
    end

    always_comb begin
        found = 1'b0;
        sel   = 3'd0;
        idx   = 4'd0;
        for (int k = 0; k < 7; k++) begin
            idx = {1'b0, rr_q} + 4'(k);
            if (idx >= 4'd7) idx = idx - 4'd7;
            if (!found && pending[idx[2:0]]) begin
                found = 1'b1;
                sel   = idx[2:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        load_pend_d = load_pend_q;
        msg_num_d   = msg_num_q;
        msg_val_d   = msg_val_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        for (int i = 1; i < 7; i++) shadow_d[i] = shadow_q[i];

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    msg_num_d  = cc_num[sel];
                    msg_val_d  = src_val[sel];
                    if (sel == 3'd0) load_pend_d = 1'b0;
                    for (int i = 1; i < 7; i++) begin
                        if (sel == 3'(i)) shadow_d[i] = src_val[i];
                    end
                    rr_d       = (sel == 3'd6) ? 3'd0 : sel + 3'd1;
                    state_d    = S_STATUS;
                    tx_valid_d = 1'b1;
                    tx_data_d  = STATUS_BYTE;
                end
            end
            S_STATUS: begin
                if (tx_valid_q && tx_ready) begin
                    state_d   = S_NUM;
                    tx_data_d = {1'b0, msg_num_q};
                end
            end
            S_NUM: begin
                if (tx_valid_q && tx_ready) begin
                    state_d   = S_VAL;
                    tx_data_d = {1'b0, msg_val_q};
                end
            end
            default: begin
                if (tx_valid_q && tx_ready) begin
                    state_d    = S_IDLE;
                    tx_valid_d = 1'b0;
                    tx_data_d  = 8'd0;
                end
            end
        endcase

        // A request arriving in the same cycle as a load capture must not be lost.
        if (wtb_load_req) load_pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rr_q        <= 3'd0;
            load_pend_q <= 1'b0;
            msg_num_q   <= 7'd0;
            msg_val_q   <= 7'd0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'd0;
            for (int i = 1; i < 7; i++) shadow_q[i] <= 7'd0;
            shadow_q[5] <= 7'd127;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            load_pend_q <= load_pend_d;
            msg_num_q   <= msg_num_d;
            msg_val_q   <= msg_val_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            for (int i = 1; i < 7; i++) shadow_q[i] <= shadow_d[i];
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign busy     = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_cc_encoder.sv
// tb_cc_encoder: transaction-level model plus directed CC scenarios for two
// encoder instances (channel 0 and channel 5) sharing one stimulus.
`default_nettype none

module tb_cc_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] wtb_num = 7'd0, wfm_num = 7'd0;
    logic [6:0] adsr_a = 7'd0, adsr_d = 7'd0, adsr_s = 7'd127, adsr_r = 7'd0;
    logic       wtb_load_req = 1'b0;
    logic       tx_ready = 1'b1;
    logic [7:0] tx_data0, tx_data5;
    logic       tx_valid0, tx_valid5, busy0, busy5;

    int total = 0;
    int bad   = 0;
    int busy_cnt = 0;
    logic [7:0] rx0[$];
    logic [7:0] rx5[$];

    always #5 clk = ~clk;

    cc_encoder dut0 (
        .clk(clk), .rst(rst), .wtb_num(wtb_num), .wfm_num(wfm_num),
        .wtb_load_req(wtb_load_req), .adsr_a(adsr_a), .adsr_d(adsr_d),
        .adsr_s(adsr_s), .adsr_r(adsr_r), .tx_data(tx_data0),
        .tx_valid(tx_valid0), .tx_ready(tx_ready), .busy(busy0)
    );

    cc_encoder #(.CHANNEL(4'd5)) dut5 (
        .clk(clk), .rst(rst), .wtb_num(wtb_num), .wfm_num(wfm_num),
        .wtb_load_req(wtb_load_req), .adsr_a(adsr_a), .adsr_d(adsr_d),
        .adsr_s(adsr_s), .adsr_r(adsr_r), .tx_data(tx_data5),
        .tx_valid(tx_valid5), .tx_ready(tx_ready), .busy(busy5)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Message-level model: phase 0 idle, 1..3 = byte being offered.
    int m_phase = 0, m_rr = 0, m_num = 0, m_val = 0;
    bit m_load = 1'b0;
    int m_sh[7];
    int nums[7] = '{112, 110, 111, 73, 75, 64, 72};

    always @(posedge clk) begin
        int v[7];
        int i;
        bit hit;
        v = '{0, int'(wtb_num), int'(wfm_num), int'(adsr_a), int'(adsr_d),
              int'(adsr_s), int'(adsr_r)};
        if (!rst) begin
            m_phase = 0; m_rr = 0; m_load = 1'b0;
            m_sh = '{0, 0, 0, 0, 0, 127, 0};
        end else begin
            if (m_phase == 0) begin
                hit = 1'b0;
                for (int k = 0; k < 7; k++) begin
                    i = (m_rr + k) % 7;
                    if (!hit && ((i == 0) ? m_load : (v[i] != m_sh[i]))) begin
                        hit = 1'b1;
                        m_num = nums[i];
                        m_val = v[i];
                        if (i == 0) m_load = 1'b0;
                        else m_sh[i] = v[i];
                        m_rr = (i + 1) % 7;
                        m_phase = 1;
                    end
                end
            end else if (tx_ready) begin
                m_phase = (m_phase == 3) ? 0 : m_phase + 1;
            end
            if (wtb_load_req) m_load = 1'b1;
        end
    end

    function automatic int exp_byte(input int status);
        case (m_phase)
            1:       return status;
            2:       return m_num;
            3:       return m_val;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst && tx_valid0 && tx_ready) rx0.push_back(tx_data0);
        if (rst && tx_valid5 && tx_ready) rx5.push_back(tx_data5);
    end

    always @(negedge clk) begin
        chk("valid0", int'(tx_valid0), int'(m_phase != 0));
        chk("busy0",  int'(busy0),     int'(m_phase != 0));
        chk("valid5", int'(tx_valid5), int'(m_phase != 0));
        chk("busy5",  int'(busy5),     int'(m_phase != 0));
        if (m_phase != 0) begin
            chk("data0", int'(tx_data0), exp_byte(8'hB0));
            chk("data5", int'(tx_data5), exp_byte(8'hB5));
        end
        if (busy0) busy_cnt++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic chk_msg(input string name, input int num, input int val);
        chk({name, " count"}, int'(rx0.size() >= 3 && rx5.size() >= 3), 1);
        if (rx0.size() >= 3 && rx5.size() >= 3) begin
            chk({name, " status0"}, int'(rx0.pop_front()), 8'hB0);
            chk({name, " num0"},    int'(rx0.pop_front()), num);
            chk({name, " val0"},    int'(rx0.pop_front()), val);
            chk({name, " status5"}, int'(rx5.pop_front()), 8'hB5);
            chk({name, " num5"},    int'(rx5.pop_front()), num);
            chk({name, " val5"},    int'(rx5.pop_front()), val);
        end
    endtask

    task automatic chk_empty(input string name);
        chk({name, " leftover0"}, rx0.size(), 0);
        chk({name, " leftover5"}, rx5.size(), 0);
    endtask

    // Waits (bounded) until channel-0 output offers the given byte.
    task automatic wait_byte(input string name, input logic [7:0] b);
        bit seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (tx_valid0 && tx_data0 == b) seen = 1'b1;
        end
        chk({name, " seen"}, int'(seen), 1);
    endtask

    initial begin
        run(3);
        rst = 1'b1;

        // Defaults match the reset shadows: nothing may be sent.
        run(50);
        chk_empty("idle");
        chk("idle busy", int'(busy0), 0);

        busy_cnt = 0;
        adsr_a = 7'd100;
        run(10);
        chk_msg("attack", 8'h49, 8'h64);
        chk("attack busy cycles", busy_cnt, 3);
        chk_empty("attack");

        step(); wtb_load_req = 1'b1;
        step(); wtb_load_req = 1'b0;
        run(10);
        chk_msg("load", 8'h70, 8'h00);
        chk_empty("load");

        wtb_num = 7'd3; wfm_num = 7'd9; adsr_s = 7'd20;
        run(20);
        chk_msg("multi wtb", 110, 3);
        chk_msg("multi wfm", 111, 9);
        chk_msg("multi sus", 64, 20);
        wfm_num = 7'd1; wtb_num = 7'd2;
        run(15);
        chk_msg("rr wtb", 110, 2);
        chk_msg("rr wfm", 111, 1);
        chk_empty("rr");

        adsr_d = 7'd50;
        wait_byte("stall", 8'h4B);
        #1 tx_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall hold data", int'(tx_data0), 8'h4B);
            chk("stall hold valid", int'(tx_valid0), 1);
        end
        #1 tx_ready = 1'b1;
        run(10);
        chk_msg("stall", 8'h4B, 8'h32);
        chk_empty("stall");

        wtb_num = 7'd0; wfm_num = 7'd0; adsr_a = 7'd0; adsr_d = 7'd0; adsr_s = 7'd127;
        run(30);
        chk_msg("restore sus", 64, 127);
        chk_msg("restore wtb", 110, 0);
        chk_msg("restore wfm", 111, 0);
        chk_msg("restore atk", 73, 0);
        chk_msg("restore dec", 75, 0);
        chk_empty("restore");

        adsr_r = 7'd5;
        wait_byte("abort", 8'h05);
        #1 adsr_r = 7'd0;
        #1 rst = 1'b0;
        #1;
        chk("abort valid", int'(tx_valid0), 0);
        chk("abort busy", int'(busy0), 0);
        chk("abort data", int'(tx_data0), 0);
        rx0.delete();
        rx5.delete();
        @(negedge clk);
        #2 rst = 1'b1;
        run(20);
        chk_empty("after reset");

        adsr_d = 7'd10;
        wait_byte("midchange", 8'h4B);
        #1 adsr_d = 7'd11; adsr_a = 7'd9;
        step(); adsr_a = 7'd0;
        run(20);
        chk_msg("midchange first", 8'h4B, 8'h0A);
        chk_msg("midchange second", 8'h4B, 8'h0B);
        chk_empty("midchange");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
